// File: rtl/bin_to_bcd_seq.sv
// Sequential binary-to-BCD converter using shift-and-add-3, one input bit per clock.
// It feeds the ones/tens inputs of the two-digit seven-segment stage and flags
// results above 99, which that stage cannot show.
// Optional build macro: SATURATE_99_EN. When it is defined, results above 99 are
// clamped to "99". When it is undefined, the true digits are kept.
module bin_to_bcd_seq #(
  parameter int IN_W = 8
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            start,
  input  logic [IN_W-1:0] bin,
  output logic            busy,
  output logic            done,
  output logic [3:0]      ones,
  output logic [3:0]      tens,
  output logic [3:0]      hundreds,
  output logic            ovf
);

  typedef enum logic [1:0] {
    IDLE,
    SHIFT,
    DONE
  } state_t;

  state_t          state_q, state_d;
  logic [IN_W-1:0] binSr_q, binSr_d;
  logic [11:0]     work_q, work_d;
  logic [11:0]     workAdj;
  logic [3:0]      cnt_q, cnt_d;
  logic [3:0]      ones_q, ones_d;
  logic [3:0]      tens_q, tens_d;
  logic [3:0]      hundreds_q, hundreds_d;
  logic            ovf_q, ovf_d;
  logic [3:0]      loadOnes, loadTens, loadHundreds;
  logic            loadOvf;

  // Add-3 correction on each work nibble independently, with no carry between digits
  always_comb begin
    workAdj = work_q;
    for (int i = 0; i < 3; i++) begin
      if (work_q[4*i +: 4] >= 4'd5) begin
        workAdj[4*i +: 4] = work_q[4*i +: 4] + 4'd3;
      end
    end
  end

  // Values captured into the output registers when a conversion completes
  always_comb begin
    loadHundreds = work_q[11:8];
    loadTens     = work_q[7:4];
    loadOnes     = work_q[3:0];
    loadOvf      = (work_q[11:8] != 4'd0);
`ifdef SATURATE_99_EN
    if (loadOvf) begin
      loadHundreds = 4'd0;
      loadTens     = 4'd9;
      loadOnes     = 4'd9;
    end
`endif
  end

  // Next-state logic.
  // A SHIFT cycle that sees cnt already at zero does no shifting. It only loads
  // the finished digits and enters DONE. This gives IN_W+1 clocks of latency.
  always_comb begin
    state_d    = state_q;
    binSr_d    = binSr_q;
    work_d     = work_q;
    cnt_d      = cnt_q;
    ones_d     = ones_q;
    tens_d     = tens_q;
    hundreds_d = hundreds_q;
    ovf_d      = ovf_q;
    case (state_q)
      IDLE, DONE: begin
        if (start) begin
          binSr_d = bin;
          work_d  = '0;
          cnt_d   = 4'(IN_W);
          state_d = SHIFT;
        end else begin
          state_d = IDLE;
        end
      end
      SHIFT: begin
        if (cnt_q != 4'd0) begin
          work_d  = {workAdj[10:0], binSr_q[IN_W-1]};
          binSr_d = binSr_q << 1;
          cnt_d   = cnt_q - 4'd1;
        end else begin
          ones_d     = loadOnes;
          tens_d     = loadTens;
          hundreds_d = loadHundreds;
          ovf_d      = loadOvf;
          state_d    = DONE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State and datapath registers. Reset discards any partial conversion.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      binSr_q    <= '0;
      work_q     <= '0;
      cnt_q      <= '0;
      ones_q     <= '0;
      tens_q     <= '0;
      hundreds_q <= '0;
      ovf_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      binSr_q    <= binSr_d;
      work_q     <= work_d;
      cnt_q      <= cnt_d;
      ones_q     <= ones_d;
      tens_q     <= tens_d;
      hundreds_q <= hundreds_d;
      ovf_q      <= ovf_d;
    end
  end

  assign busy     = (state_q == SHIFT);
  assign done     = (state_q == DONE);
  assign ones     = ones_q;
  assign tens     = tens_q;
  assign hundreds = hundreds_q;
  assign ovf      = ovf_q;

endmodule

// File: tb/tb_bin_to_bcd_seq.sv
// Self-checking bench for bin_to_bcd_seq.
// It uses a vector table plus hand-written corner sequences. A scoreboard queue
// holds the expected digits, and a monitor pops and compares them on each done pulse.
// Honours SATURATE_99_EN in the same way as the design.
module tb_bin_to_bcd_seq;
  localparam int IN_W = 8;

  logic            clk = 1'b0;
  logic            rst = 1'b1;
  logic            start = 1'b0;
  logic [IN_W-1:0] bin = '0;
  logic            busy, done, ovf;
  logic [3:0]      ones, tens, hundreds;

  typedef struct packed {
    logic [3:0] o;
    logic [3:0] t;
    logic [3:0] h;
    logic       v;
  } exp_t;

  typedef struct packed {
    logic [7:0] b;
    exp_t       e;
  } vec_t;

  exp_t sbQ[$];
  exp_t heldExp = '0;
  vec_t vecs[9];
  int   errors = 0;
  int   checks = 0;

  bin_to_bcd_seq #(.IN_W(IN_W)) dut (
    .clk(clk),
    .rst(rst),
    .start(start),
    .bin(bin),
    .busy(busy),
    .done(done),
    .ones(ones),
    .tens(tens),
    .hundreds(hundreds),
    .ovf(ovf)
  );

  // Free-running 10 ns clock
  always #5 clk = ~clk;

  // Abort if the run gets stuck somewhere
  initial begin
    #200000;
    $display("[TB] FAIL watchdog: got timeout expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("[TB] FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  function automatic exp_t model(input int v);
    exp_t e;
    e.o = 4'(v % 10);
    e.t = 4'((v / 10) % 10);
    e.h = 4'(v / 100);
    e.v = (v > 99);
`ifdef SATURATE_99_EN
    if (v > 99) begin
      e.o = 4'd9;
      e.t = 4'd9;
      e.h = 4'd0;
    end
`endif
    return e;
  endfunction

  // Raise start so that the next rising edge accepts it. Then drop start and
  // scramble bin to show that only the captured copy is used.
  task automatic applyStimulus(input logic [7:0] b, input exp_t e, input bit expectResult);
    start = 1'b1;
    bin   = b;
    if (expectResult) sbQ.push_back(e);
    @(posedge clk);
    #1;
    start = 1'b0;
    bin   = IN_W'($urandom);
  endtask

  // Count rising edges until done is seen, bounded so a dead DUT cannot hang the run
  task automatic waitDone(input int expCycles, input string name);
    int cycles = 0;
    bit seen = 1'b0;
    while (!seen && cycles < 40) begin
      @(posedge clk);
      cycles++;
      @(negedge clk);
      if (done) seen = 1'b1;
      else if (cycles == 1) checkOutput({name, " busy"}, int'(busy), 1);
    end
    checkOutput({name, " done seen"}, int'(seen), 1);
    checkOutput({name, " latency"}, cycles, expCycles);
    checkOutput({name, " busy during done"}, int'(busy), 0);
  endtask

  // Monitor: pops the scoreboard on done, otherwise checks that the outputs hold
  initial begin
    forever begin
      @(negedge clk);
      if (!rst) begin
        if (done) begin
          checkOutput("scoreboard entry at done", int'(sbQ.size() > 0), 1);
          if (sbQ.size() > 0) begin
            exp_t e;
            e = sbQ.pop_front();
            checkOutput("ones", int'(ones), int'(e.o));
            checkOutput("tens", int'(tens), int'(e.t));
            checkOutput("hundreds", int'(hundreds), int'(e.h));
            checkOutput("ovf", int'(ovf), int'(e.v));
            heldExp = e;
          end
        end else begin
          checkOutput("held outputs", int'({ones, tens, hundreds, ovf}), int'(heldExp));
        end
      end
    end
  end

  // Main test sequence
  initial begin
    vecs[0] = '{b: 8'd57,  e: '{o: 4'd7, t: 4'd5, h: 4'd0, v: 1'b0}};
`ifdef SATURATE_99_EN
    vecs[1] = '{b: 8'd255, e: '{o: 4'd9, t: 4'd9, h: 4'd0, v: 1'b1}};
    vecs[4] = '{b: 8'd100, e: '{o: 4'd9, t: 4'd9, h: 4'd0, v: 1'b1}};
    vecs[8] = '{b: 8'd199, e: '{o: 4'd9, t: 4'd9, h: 4'd0, v: 1'b1}};
`else
    vecs[1] = '{b: 8'd255, e: '{o: 4'd5, t: 4'd5, h: 4'd2, v: 1'b1}};
    vecs[4] = '{b: 8'd100, e: '{o: 4'd0, t: 4'd0, h: 4'd1, v: 1'b1}};
    vecs[8] = '{b: 8'd199, e: '{o: 4'd9, t: 4'd9, h: 4'd1, v: 1'b1}};
`endif
    vecs[2] = '{b: 8'd0,   e: '{o: 4'd0, t: 4'd0, h: 4'd0, v: 1'b0}};
    vecs[3] = '{b: 8'd99,  e: '{o: 4'd9, t: 4'd9, h: 4'd0, v: 1'b0}};
    vecs[5] = '{b: 8'd1,   e: '{o: 4'd1, t: 4'd0, h: 4'd0, v: 1'b0}};
    vecs[6] = '{b: 8'd9,   e: '{o: 4'd9, t: 4'd0, h: 4'd0, v: 1'b0}};
    vecs[7] = '{b: 8'd10,  e: '{o: 4'd0, t: 4'd1, h: 4'd0, v: 1'b0}};

    // Reset for two cycles, then idle without start
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    repeat (5) begin
      @(negedge clk);
      checkOutput("idle busy", int'(busy), 0);
      checkOutput("idle done", int'(done), 0);
    end

    // Table vectors, each started back-to-back in the previous DONE cycle
    for (int i = 0; i < 9; i++) begin
      applyStimulus(vecs[i].b, vecs[i].e, 1'b1);
      waitDone(IN_W + 1, $sformatf("vec%0d", i));
    end
    repeat (3) begin
      @(negedge clk);
      checkOutput("done single pulse", int'(done), 0);
      checkOutput("busy after return to idle", int'(busy), 0);
    end

    // A start raised during SHIFT must be ignored
    applyStimulus(8'd42, '{o: 4'd2, t: 4'd4, h: 4'd0, v: 1'b0}, 1'b1);
    @(posedge clk);
    @(posedge clk);
    #1;
    start = 1'b1;
    bin   = IN_W'(13);
    @(posedge clk);
    #1;
    start = 1'b0;
    waitDone(IN_W + 1 - 3, "ignored start");
    repeat (2) @(negedge clk);

    // Reset in the middle of a conversion discards it
    applyStimulus(8'd200, '0, 1'b0);
    repeat (4) @(posedge clk);
    #1;
    rst     = 1'b1;
    heldExp = '0;
    @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    checkOutput("post-reset busy", int'(busy), 0);
    checkOutput("post-reset done", int'(done), 0);
    checkOutput("post-reset digits", int'({hundreds, tens, ones}), 0);
    checkOutput("post-reset ovf", int'(ovf), 0);
    repeat (12) begin
      @(negedge clk);
      checkOutput("no done after aborted conversion", int'(done), 0);
    end
    applyStimulus(8'd8, '{o: 4'd8, t: 4'd0, h: 4'd0, v: 1'b0}, 1'b1);
    waitDone(IN_W + 1, "after reset");

    // A few random values checked against the arithmetic model
    for (int i = 0; i < 4; i++) begin
      int v;
      v = int'($urandom_range(0, 255));
      applyStimulus(8'(v), model(v), 1'b1);
      waitDone(IN_W + 1, $sformatf("rand%0d", i));
    end

    repeat (3) @(negedge clk);
    checkOutput("scoreboard drained", sbQ.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
